// File: rtl/krnl_partialknn_local_buf_ctrl.sv
// Initiator for one single-port local buffer (address0/ce0/we0/d0/q0).
// A load command streams input words into the buffer. A scan command reads
// a contiguous, wrapping range and presents it as a back-pressurable stream.
// Reads are credit-limited: a read is only issued when the output FIFO can
// hold every word that is still in flight.
//
// Handshake semantics: a transfer occurs on a rising edge where valid and
// ready are both high; ready never depends on the same interface's valid,
// and valid does not wait for ready.
module krnl_partialknn_local_buf_ctrl #(
  parameter int DataWidth    = 256,
  parameter int AddressRange = 2048,
  parameter int AddressWidth = 11,
  parameter int ReadLatency  = 2,
  parameter int FifoDepth    = ReadLatency + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [AddressWidth-1:0] cmd_base,
  input  logic [AddressWidth:0]   cmd_len,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0,
  output logic [1:0]              dbg_state
);

  localparam int AW = AddressWidth;
  localparam int RL = ReadLatency;
  localparam int FD = FifoDepth;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1) + 1;
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_base;
  logic [AW:0]       r_len;
  logic [AW:0]       r_i;
  logic [AW:0]       r_o;
  logic [RL-1:0]     r_vld_sr;
  logic [DataWidth-1:0] r_fifo [FD];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_in_load;
  logic              w_in_scan;
  logic              w_more;
  logic              w_wr;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_inflight;
  logic [AW-1:0]     w_addr;

  assign w_in_load = (r_state == S_LOAD) & ~reset;
  assign w_in_scan = (r_state == S_SCAN) & ~reset;
  assign w_more    = r_i < r_len;

  // Count reads still travelling through the memory pipeline.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < RL; k++) w_inflight = w_inflight + CW'(r_vld_sr[k]);
  end

  assign in_ready  = w_in_load & w_more;
  assign w_wr      = in_ready & in_valid;
  // Credit check uses registered occupancy; a pop this cycle frees its slot next cycle.
  assign w_issue   = w_in_scan & w_more & ((w_inflight + r_count) < CW'(FD));
  assign w_push    = r_vld_sr[RL-1];
  assign out_valid = w_in_scan & (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = r_fifo[r_rptr];

  // Address wraps naturally because the buffer depth is a power of two.
  assign w_addr       = r_base + r_i[AW-1:0];
  assign mem_address0 = reset ? '0 : w_addr;
  assign mem_ce0      = w_wr | w_issue;
  assign mem_we0      = w_wr;
  assign mem_d0       = w_wr ? in_data : '0;
  assign cmd_ready    = (r_state == S_IDLE) & ~reset;
  assign done         = (r_state == S_DONE) & ~reset;
  assign dbg_state    = r_state;

  // Command FSM: capture, count issued/delivered words, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_i     <= '0;
      r_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_base <= cmd_base;
            r_len  <= cmd_len;
            r_i    <= '0;
            r_o    <= '0;
            if (cmd_len == '0)  r_state <= S_DONE;
            else if (cmd_op)    r_state <= S_SCAN;
            else                r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_wr) begin
            r_i <= r_i + ONE;
            if (r_i == r_len - ONE) r_state <= S_DONE;
          end
        end
        S_SCAN: begin
          if (w_issue) r_i <= r_i + ONE;
          if (w_pop) begin
            r_o <= r_o + ONE;
            if (r_o == r_len - ONE) r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-valid pipeline and FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_sr <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_vld_sr[0] <= w_issue;
      for (int k = 1; k < RL; k++) r_vld_sr[k] <= r_vld_sr[k-1];
      if (w_push) r_wptr <= (r_wptr == PW'(FD - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(FD - 1)) ? '0 : r_rptr + PW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (~w_push & w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage; contents are meaningless once occupancy is cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= mem_q0;
  end

endmodule

// File: tb/tb_krnl_partialknn_local_buf_ctrl.sv
// Bench for krnl_partialknn_local_buf_ctrl: memory model with ReadLatency
// read pipeline, golden buffer image, per-scenario tasks.
module tb_krnl_partialknn_local_buf_ctrl;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int AR = 2048;
  localparam int RL = 2;
  localparam int FD = RL + 2;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0;
  logic          mem_we0;
  logic [DW-1:0] mem_d0;
  logic [DW-1:0] mem_q0;
  logic [1:0]    dbg_state;

  krnl_partialknn_local_buf_ctrl #(
    .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW),
    .ReadLatency(RL), .FifoDepth(FD)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .mem_address0(mem_address0), .mem_ce0(mem_ce0),
    .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Memory model: single port, ReadLatency-cycle read data; garbage otherwise.
  logic [DW-1:0] mem [AR];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) mem[mem_address0] <= mem_d0;
    rd_pipe[0] <= (mem_ce0 && !mem_we0) ? mem[mem_address0] : rand_word();
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_q0 = rd_pipe[RL-1];

  // Golden buffer image, written from the load commands the bench issues.
  logic [DW-1:0] exp_mem [AR];

  // Credit monitor: reads issued but not yet delivered may never exceed FD.
  int outstanding = 0;
  int ce_cnt = 0;
  always @(negedge clk) begin
    #2;
    if (reset) outstanding = 0;
    else begin
      if (mem_ce0) ce_cnt++;
      if (mem_ce0 && !mem_we0) begin
        outstanding++;
        n_checks++;
        if (outstanding > FD) begin
          n_fail++;
          $display("FAIL credit_bound outstanding=%0d limit=%0d cyc=%0d", outstanding, FD, cyc);
        end
      end
      if (out_valid && out_ready) outstanding--;
    end
  end

  // Observation storage filled by the driver tasks
  logic [DW-1:0] ld_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  bit            ww_q[$];
  int            wc_q[$];
  int            pc_q[$];
  int acc_edge, done_cyc, done_cnt, first_valid, rd_before_pop;
  bit to_flag;

  task automatic send_cmd(input bit op, input int base, input int len);
    int t;
    @(negedge clk);
    cmd_op = op; cmd_base = AW'(base); cmd_len = (AW + 1)'(len); cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) to_flag = 1'b1;
    acc_edge = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_load(input int base, input int len, input int mode);
    int idx;
    wa_q.delete(); wd_q.delete(); ww_q.delete(); wc_q.delete();
    done_cyc = -1; done_cnt = 0; to_flag = 1'b0; idx = 0;
    send_cmd(1'b0, base, len);
    for (int t = 0; t < 400; t++) begin
      in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data = (idx < ld_q.size()) ? ld_q[idx] : rand_word();
      #1;
      if (in_valid && in_ready) idx++;
      if (mem_ce0) begin
        wa_q.push_back(mem_address0); wd_q.push_back(mem_d0);
        ww_q.push_back(mem_we0); wc_q.push_back(cyc);
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (done_cyc < 0) to_flag = 1'b1;
  endtask

  task automatic run_scan(input int base, input int len, input int mode);
    got_q.delete(); pc_q.delete();
    done_cyc = -1; done_cnt = 0; to_flag = 1'b0; first_valid = -1; rd_before_pop = 0;
    send_cmd(1'b1, base, len);
    for (int t = 0; t < 400; t++) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 2 && cyc - acc_edge < 10) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_ce0 && !mem_we0 && got_q.size() == 0) rd_before_pop++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin got_q.push_back(out_data); pc_q.push_back(cyc); end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (done_cyc < 0) to_flag = 1'b1;
  endtask

  function automatic void build_exp(input int base, input int len);
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(exp_mem[(base + k) % AR]);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    n_checks++; if ({in_ready, out_valid, done, mem_ce0, mem_we0} !== 5'b0) begin
      n_fail++; $display("FAIL rst_ctrl got=%b exp=00000", {in_ready, out_valid, done, mem_ce0, mem_we0}); end
    n_checks++; if (mem_address0 !== '0 || mem_d0 !== '0) begin
      n_fail++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", mem_address0, mem_d0); end
    reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle got=%b%b exp=00", out_valid, in_ready); end
  endtask

  // Shared load-result checks written out per task would bloat; each test
  // compares its own observations below.
  task automatic test_load_basic();
    ld_q.delete();
    for (int k = 0; k < 8; k++) ld_q.push_back(DW'(32'h10 + k));
    run_load(0, 8, 0);
    n_checks++; if (to_flag) begin n_fail++; $display("FAIL load_basic_timeout got=1 exp=0"); end
    n_checks++; if (wa_q.size() != 8) begin n_fail++; $display("FAIL load_basic_count got=%0d exp=8", wa_q.size()); end
    for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
      n_checks++;
      if (wa_q[k] !== AW'(k) || wd_q[k] !== DW'(32'h10 + k) || ww_q[k] !== 1'b1) begin
        n_fail++; $display("FAIL load_basic_wr%0d got=%h/%h/%b exp=%h/%h/1", k, wa_q[k], wd_q[k], ww_q[k], k, 32'h10 + k);
      end
    end
    if (wa_q.size() == 8) begin
      n_checks++; if (wc_q[7] - wc_q[0] != 7) begin n_fail++; $display("FAIL load_basic_rate got=%0d exp=7", wc_q[7] - wc_q[0]); end
      n_checks++; if (done_cyc != wc_q[7] + 1) begin n_fail++; $display("FAIL load_basic_done_cyc got=%0d exp=%0d", done_cyc, wc_q[7] + 1); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL load_basic_done_pulse got=%0d exp=1", done_cnt); end
    for (int k = 0; k < 8; k++) exp_mem[k] = ld_q[k];
  endtask

  task automatic test_scan_basic();
    run_scan(0, 8, 0);
    build_exp(0, 8);
    n_checks++; if (to_flag) begin n_fail++; $display("FAIL scan_basic_timeout got=1 exp=0"); end
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL scan_basic_count got=%0d exp=8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL scan_basic_w%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    n_checks++; if (first_valid - acc_edge != RL + 1) begin
      n_fail++; $display("FAIL scan_basic_latency got=%0d exp=%0d", first_valid - acc_edge, RL + 1); end
    if (pc_q.size() == 8) begin
      n_checks++; if (pc_q[7] - pc_q[0] != 7) begin n_fail++; $display("FAIL scan_basic_rate got=%0d exp=7", pc_q[7] - pc_q[0]); end
      n_checks++; if (done_cyc != pc_q[7] + 1) begin n_fail++; $display("FAIL scan_basic_done_cyc got=%0d exp=%0d", done_cyc, pc_q[7] + 1); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL scan_basic_done_pulse got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap();
    ld_q.delete();
    for (int k = 0; k < 4; k++) ld_q.push_back(rand_word());
    run_load(2046, 4, 0);
    n_checks++; if (to_flag || wa_q.size() != 4) begin n_fail++; $display("FAIL wrap_load_count got=%0d exp=4", wa_q.size()); end
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      n_checks++;
      if (wa_q[k] !== AW'((2046 + k) % AR) || wd_q[k] !== ld_q[k]) begin
        n_fail++; $display("FAIL wrap_load_wr%0d got=%0d exp=%0d", k, wa_q[k], (2046 + k) % AR);
      end
    end
    for (int k = 0; k < 4; k++) exp_mem[(2046 + k) % AR] = ld_q[k];
    run_scan(2046, 4, 0);
    build_exp(2046, 4);
    n_checks++; if (to_flag || got_q.size() != 4) begin n_fail++; $display("FAIL wrap_scan_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL wrap_scan_w%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    for (int pass = 0; pass < 2; pass++) begin
      run_scan(0, 8, (pass == 0) ? 2 : 1);
      build_exp(0, 8);
      n_checks++; if (to_flag || got_q.size() != 8) begin n_fail++; $display("FAIL bp%0d_count got=%0d exp=8", pass, got_q.size()); end
      for (int k = 0; k < 8 && k < got_q.size(); k++) begin
        n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp%0d_w%0d got=%h exp=%h", pass, k, got_q[k], exp_q[k]); end
      end
      if (pc_q.size() == 8) begin
        n_checks++; if (done_cyc != pc_q[7] + 1) begin n_fail++; $display("FAIL bp%0d_done_cyc got=%0d exp=%0d", pass, done_cyc, pc_q[7] + 1); end
      end
      if (pass == 0) begin
        n_checks++; if (rd_before_pop != FD) begin n_fail++; $display("FAIL bp_stall_reads got=%0d exp=%0d", rd_before_pop, FD); end
      end
    end
  endtask

  task automatic test_len_zero();
    int ce0_before;
    for (int op = 0; op < 2; op++) begin
      ce0_before = ce_cnt;
      if (op == 0) run_load(5, 0, 0); else run_scan(5, 0, 0);
      n_checks++; if (to_flag || done_cyc != acc_edge) begin n_fail++; $display("FAIL len0_op%0d_done_cyc got=%0d exp=%0d", op, done_cyc, acc_edge); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL len0_op%0d_done_pulse got=%0d exp=1", op, done_cnt); end
      n_checks++; if (ce_cnt != ce0_before) begin n_fail++; $display("FAIL len0_op%0d_ce0 got=%0d exp=0", op, ce_cnt - ce0_before); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int pops;
    bit saw_done;
    pops = 0; saw_done = 1'b0; to_flag = 1'b0;
    send_cmd(1'b1, 0, 8);
    for (int t = 0; t < 100 && pops < 3; t++) begin
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) pops++;
      @(negedge clk);
    end
    n_checks++; if (pops != 3) begin n_fail++; $display("FAIL rms_pops got=%0d exp=3", pops); end
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || mem_ce0 !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rms_during got=%b%b%b exp=000", out_valid, mem_ce0, done); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || mem_ce0 !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rms_after got=%b%b%b exp=001", out_valid, mem_ce0, cmd_ready); end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); #1;
      if (done || out_valid) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL rms_no_done got=1 exp=0"); end
    out_ready = 1'b0;
    run_scan(4, 2, 0);
    build_exp(4, 2);
    n_checks++; if (to_flag || got_q.size() != 2) begin n_fail++; $display("FAIL rms_fresh_count got=%0d exp=2", got_q.size()); end
    for (int k = 0; k < 2 && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rms_fresh_w%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    int base, len;
    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, AR - 1);
      len = $urandom_range(1, 24);
      ld_q.delete();
      for (int k = 0; k < len; k++) ld_q.push_back(rand_word());
      run_load(base, len, 1);
      n_checks++; if (to_flag || wa_q.size() != len) begin n_fail++; $display("FAIL rnd%0d_load_count got=%0d exp=%0d", it, wa_q.size(), len); end
      for (int k = 0; k < len && k < wa_q.size(); k++) begin
        n_checks++;
        if (wa_q[k] !== AW'((base + k) % AR) || wd_q[k] !== ld_q[k] || ww_q[k] !== 1'b1) begin
          n_fail++; $display("FAIL rnd%0d_wr%0d got=%0d exp=%0d", it, k, wa_q[k], (base + k) % AR);
        end
      end
      for (int k = 0; k < len; k++) exp_mem[(base + k) % AR] = ld_q[k];
      run_scan(base, len, 1);
      build_exp(base, len);
      n_checks++; if (to_flag || got_q.size() != len) begin n_fail++; $display("FAIL rnd%0d_scan_count got=%0d exp=%0d", it, got_q.size(), len); end
      for (int k = 0; k < len && k < got_q.size(); k++) begin
        n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd%0d_w%0d got=%h exp=%h", it, k, got_q[k], exp_q[k]); end
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_done_pulse got=%0d exp=1", it, done_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_load_basic();
    test_scan_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_reset_mid_scan();
    test_random();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
